// File: rtl/pc_gen.sv
// Fetch PC generator: owns the architectural fetch PC, the ibus request handshake,
// and a one-word hold buffer that keeps the fetched instruction alive across stalls.
module pc_gen #(
   parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_addr_ok,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic [63:0] pc_f,
   output logic [31:0] instr_f,
   output logic        valid_f
);

   typedef enum logic [1:0] {BOOT, REQ, HOLD, DISCARD} state_t;

   state_t      state;
   logic [63:0] pc;
   logic [63:0] pend_pc;
   logic [31:0] ibuf;
   logic [63:0] redirect_aligned;
   logic        unused_addr_ok;

   assign unused_addr_ok   = iresp_addr_ok;
   assign redirect_aligned = {redirect_pc[63:2], 2'b00};

   assign ireq_valid = (state == REQ) || (state == DISCARD);
   assign ireq_addr  = pc;
   assign pc_f       = pc;

   // A redirect always kills the word presented this cycle, whatever its source.
   always_comb begin
      valid_f = 1'b0;
      instr_f = 32'h0;
      case (state)
         REQ: begin
            valid_f = iresp_data_ok && !redirect_valid;
            instr_f = iresp_data;
         end
         HOLD: begin
            valid_f = !redirect_valid;
            instr_f = ibuf;
         end
         DISCARD: begin
            instr_f = iresp_data;
         end
         default: begin
            valid_f = 1'b0;
            instr_f = 32'h0;
         end
      endcase
   end

   // The request address must stay put until data_ok, so a redirect seen while a
   // request is outstanding is parked in pend_pc and applied when the old word lands.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= BOOT;
         pc      <= RESET_PC;
         pend_pc <= 64'h0;
         ibuf    <= 32'h0;
      end else begin
         case (state)
            BOOT: begin
               state <= REQ;
            end
            REQ: begin
               if (iresp_data_ok) begin
                  if (redirect_valid) begin
                     pc <= redirect_aligned;
                  end else if (stall) begin
                     ibuf  <= iresp_data;
                     state <= HOLD;
                  end else begin
                     pc <= pc + 64'd4;
                  end
               end else if (redirect_valid) begin
                  pend_pc <= redirect_aligned;
                  state   <= DISCARD;
               end
            end
            HOLD: begin
               if (redirect_valid) begin
                  pc    <= redirect_aligned;
                  state <= REQ;
               end else if (!stall) begin
                  pc    <= pc + 64'd4;
                  state <= REQ;
               end
            end
            DISCARD: begin
               if (iresp_data_ok) begin
                  pc    <= redirect_valid ? redirect_aligned : pend_pc;
                  state <= REQ;
               end else if (redirect_valid) begin
                  pend_pc <= redirect_aligned;
               end
            end
            default: begin
               state <= BOOT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed fetch scenarios followed by random bus,
// stall and redirect traffic, all compared against a transaction-level fetch model.
module tb_pc_gen;

   localparam logic [63:0] RESET_PC = 64'h8000_0000;

   logic        clk;
   logic        reset;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_addr_ok;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;
   logic        stall;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic [63:0] pc_f;
   logic [31:0] instr_f;
   logic        valid_f;

   int checks = 0;
   int errors = 0;

   // Model: where fetch is, whether a delivered word is parked waiting for F/D,
   // and whether the in-flight bus word is already known to be stale.
   bit          m_booting;
   bit          m_word_parked;
   bit          m_stale_inflight;
   logic [63:0] m_fetch_pc;
   logic [63:0] m_next_target;
   logic [31:0] m_parked_word;

   pc_gen #(.RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .reset          (reset),
      .ireq_valid     (ireq_valid),
      .ireq_addr      (ireq_addr),
      .iresp_addr_ok  (iresp_addr_ok),
      .iresp_data_ok  (iresp_data_ok),
      .iresp_data     (iresp_data),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .pc_f           (pc_f),
      .instr_f        (instr_f),
      .valid_f        (valid_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic model_reset();
      m_booting        = 1'b1;
      m_word_parked    = 1'b0;
      m_stale_inflight = 1'b0;
      m_fetch_pc       = RESET_PC;
      m_next_target    = 64'h0;
      m_parked_word    = 32'h0;
   endtask

   task automatic check_output();
      bit          exp_req;
      bit          exp_valid;
      logic [31:0] exp_instr;
      exp_req   = !m_booting && !m_word_parked;
      exp_valid = 1'b0;
      exp_instr = 32'h0;
      if (!m_booting) begin
         if (m_word_parked) begin
            exp_valid = !redirect_valid;
            exp_instr = m_parked_word;
         end else begin
            exp_valid = iresp_data_ok && !redirect_valid && !m_stale_inflight;
            exp_instr = iresp_data;
         end
      end
      check_val("ireq_valid", {63'h0, ireq_valid}, {63'h0, exp_req});
      check_val("ireq_addr", ireq_addr, m_fetch_pc);
      check_val("pc_f", pc_f, m_fetch_pc);
      check_val("valid_f", {63'h0, valid_f}, {63'h0, exp_valid});
      check_val("instr_f", {32'h0, instr_f}, {32'h0, exp_instr});
   endtask

   task automatic model_clock(input bit dok, input bit stl, input bit rdv, input logic [63:0] rpc,
                              input logic [31:0] data);
      logic [63:0] target;
      target = rpc & ~64'h3;
      if (m_booting) begin
         m_booting = 1'b0;
      end else if (m_word_parked) begin
         if (rdv) begin
            m_fetch_pc    = target;
            m_word_parked = 1'b0;
         end else if (!stl) begin
            m_fetch_pc    = m_fetch_pc + 64'd4;
            m_word_parked = 1'b0;
         end
      end else if (m_stale_inflight) begin
         if (dok) begin
            m_fetch_pc       = rdv ? target : m_next_target;
            m_stale_inflight = 1'b0;
         end else if (rdv) begin
            m_next_target = target;
         end
      end else if (dok) begin
         if (rdv) m_fetch_pc = target;
         else if (stl) begin
            m_word_parked = 1'b1;
            m_parked_word = data;
         end else m_fetch_pc = m_fetch_pc + 64'd4;
      end else if (rdv) begin
         m_stale_inflight = 1'b1;
         m_next_target    = target;
      end
   endtask

   // Called at a negedge; drives one cycle, checks before the edge, ends at the next negedge.
   task automatic apply_stimulus(input bit dok, input bit stl, input bit rdv, input logic [63:0] rpc,
                                 input logic [31:0] data);
      iresp_data_ok  = dok;
      iresp_addr_ok  = dok;
      stall          = stl;
      redirect_valid = rdv;
      redirect_pc    = rpc;
      iresp_data     = data;
      #1;
      check_output();
      @(posedge clk);
      model_clock(dok, stl, rdv, rpc, data);
      @(negedge clk);
   endtask

   task automatic reset_mid_run();
      reset         = 1'b1;
      iresp_data_ok = 1'b0;
      iresp_data    = 32'hDEAD_BEEF;
      model_reset();
      #1;
      check_output();
      iresp_data_ok = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_output();
      reset = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      iresp_addr_ok  = 1'b0;
      iresp_data_ok  = 1'b0;
      iresp_data     = 32'h0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      model_reset();
      #2;
      check_output();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Boot cycle, then back-to-back data with no stall.
      apply_stimulus(1'b1, 1'b0, 1'b1, 64'h1234, 32'h1111_1111);
      check_val("boot_to_first_req", ireq_addr, 64'h8000_0000);
      apply_stimulus(1'b1, 1'b0, 1'b0, 64'h0, 32'h0000_0013);
      check_val("seq_addr_4", ireq_addr, 64'h8000_0004);

      // Word for 80000004 arrives while F/D is stalled for three cycles.
      apply_stimulus(1'b1, 1'b1, 1'b0, 64'h0, 32'hA5A5_0001);
      for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 64'h0, 32'h5555_5555);
      check_val("hold_instr", {32'h0, instr_f}, 64'hA5A5_0001);
      apply_stimulus(1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
      check_val("after_hold_addr", ireq_addr, 64'h8000_0008);

      // Redirect to a misaligned target while 80000008 is outstanding.
      apply_stimulus(1'b0, 1'b0, 1'b1, 64'h8000_1002, 32'h0);
      for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
      check_val("discard_addr_held", ireq_addr, 64'h8000_0008);
      apply_stimulus(1'b1, 1'b0, 1'b0, 64'h0, 32'hBAD0_0008);
      check_val("redirect_target", ireq_addr, 64'h8000_1000);

      // Two redirects during one outstanding request: the later one wins.
      apply_stimulus(1'b0, 1'b0, 1'b1, 64'h9000, 32'h0);
      apply_stimulus(1'b0, 1'b0, 1'b1, 64'hA000, 32'h0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 64'h0, 32'hBAD0_1000);
      check_val("last_redirect_wins", ireq_addr, 64'hA000);

      // Redirect coincident with data in REQ, then redirect in HOLD under stall.
      apply_stimulus(1'b1, 1'b0, 1'b1, 64'hB000, 32'h0BAD_0BAD);
      check_val("redirect_with_data", ireq_addr, 64'hB000);
      apply_stimulus(1'b1, 1'b1, 1'b0, 64'h0, 32'h1234_5678);
      apply_stimulus(1'b0, 1'b1, 1'b1, 64'hC003, 32'h0);
      check_val("redirect_in_hold", ireq_addr, 64'hC000);
      check_val("req_after_hold_redirect", {63'h0, ireq_valid}, 64'h1);

      // Sequential wrap at the top of the address space.
      apply_stimulus(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 64'h0, 32'h0000_0001);
      check_val("pc_wrap", ireq_addr, 64'h0);

      // Reset in the middle of an outstanding request, with a late data_ok.
      apply_stimulus(1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
      reset_mid_run();
      apply_stimulus(1'b1, 1'b0, 1'b0, 64'h0, 32'hFEED_0000);
      check_val("restart_addr", ireq_addr, RESET_PC);

      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 199) == 0) reset_mid_run();
         else apply_stimulus($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
                             $urandom_range(0, 9) == 0, {$urandom, $urandom}, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
